// File: rtl/fta_bus_pkg.sv
// FTA command bus types shared by initiators and responders: command codes and
// the 128-bit request/response transaction structures.
package fta_bus_pkg;

   typedef enum logic [4:0] {
      CMD_NONE  = 5'd0,
      CMD_LOAD  = 5'd1,
      CMD_STORE = 5'd2,
      CMD_LOADZ = 5'd3,
      CMD_SWAP  = 5'd4
   } fta_cmd_t;

   typedef logic [7:0] fta_tid_t;

   typedef struct packed {
      fta_cmd_t       cmd;
      fta_tid_t       tid;
      logic           cyc;
      logic           stb;
      logic           we;
      logic [15:0]    sel;
      logic [31:0]    adr;
      logic [127:0]   data1;
   } fta_cmd_request128_t;

   typedef struct packed {
      fta_tid_t       tid;
      logic           ack;
      logic           rty;
      logic           err;
      logic [31:0]    adr;
      logic [127:0]   dat;
   } fta_cmd_response128_t;

endpackage

// File: rtl/fta_mem_responder_pkg.sv
// Local types for the FTA memory responder: request queue entry, engine state
// and the check for commands the line RAM can service.
package fta_mem_responder_pkg;
   import fta_bus_pkg::*;

   typedef struct packed {
      fta_cmd_t       cmd;
      fta_tid_t       tid;
      logic           we;
      logic [15:0]    sel;
      logic [31:0]    adr;
      logic [127:0]   data1;
   } fta_mreq_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } e_fta_mresp_state;

   function automatic logic fta_mreq_is_valid(input fta_cmd_t cmd, input logic [15:0] sel);
      return (sel != 16'h0000) && ((cmd == CMD_LOAD) || (cmd == CMD_STORE));
   endfunction

endpackage

// File: rtl/fta_req_fifo.sv
// Synchronous FIFO of depth D (power of two) with full/empty/count status.
// Push while full and pop while empty are ignored.
module fta_req_fifo #(
   parameter int W = 8,
   parameter int D = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [W-1:0]               wdata_i,
   output logic [W-1:0]               rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(D+1)-1:0]     count_o
);
   localparam int AW = $clog2(D);
   localparam int CW = $clog2(D+1);

   logic [W-1:0]  mem_q [D];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push_s, do_pop_s;

   always_comb begin
      do_push_s = push_i && (count_q != CW'(D));
      do_pop_s  = pop_i && (count_q != CW'(0));
      wr_d      = do_push_s ? wr_q + AW'(1) : wr_q;
      rd_d      = do_pop_s ? rd_q + AW'(1) : rd_q;
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: only slots between rd and wr are ever observed.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_q[wr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_q];
   assign full_o  = (count_q == CW'(D));
   assign empty_o = (count_q == CW'(0));
   assign count_o = count_q;

endmodule

// File: rtl/fta_mem_responder.sv
// FTA 128-bit bus responder servicing requests from a byte-lane line RAM.
// Define FTA_MEM_RESPONDER_ERR_EN to complete unsupported requests with err.
module fta_mem_responder
   import fta_bus_pkg::*;
   import fta_mem_responder_pkg::*;
#(
   parameter logic [31:0] BASE = 32'hFFF00000,
   parameter logic [31:0] MASK = 32'hFFFF0000,
   parameter int          AWID = 12,
   parameter int          QDEP = 4,
   parameter int          LAT  = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  fta_cmd_request128_t  ftas_req,
   output fta_cmd_response128_t ftas_resp
);
   logic                         cs_s, take_s, full_s, empty_s, push_s, rty_s;
   logic                         pop_s, access_s, wr_s, err_entry_s;
   logic [$clog2(QDEP+1)-1:0]    fifo_count_unused_s;
   fta_mreq_entry_t              in_entry_s, head_s;
   logic [AWID-1:0]              idx_s;
   logic [127:0]                 rd_line_s;

   e_fta_mresp_state             state_q, state_d;
   logic [2:0]                   cnt_q, cnt_d;
   fta_mreq_entry_t              cur_q, cur_d;
   logic [127:0]                 line_q, line_d;
   fta_cmd_response128_t         resp_q, resp_d;

   logic [7:0]                   ram_q [16][2**AWID];

   always_comb begin
      cs_s = ftas_req.cyc && ftas_req.stb && ((ftas_req.adr & MASK) == (BASE & MASK));
`ifdef FTA_MEM_RESPONDER_ERR_EN
      take_s = cs_s;
`else
      take_s = cs_s && fta_mreq_is_valid(ftas_req.cmd, ftas_req.sel);
`endif
      push_s = take_s && !full_s;
      rty_s  = take_s && full_s;
      in_entry_s = '{cmd: ftas_req.cmd, tid: ftas_req.tid, we: ftas_req.we, sel: ftas_req.sel,
                     adr: ftas_req.adr, data1: ftas_req.data1};
   end

   fta_req_fifo #(.W($bits(fta_mreq_entry_t)), .D(QDEP)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .wdata_i (in_entry_s),
      .rdata_o (head_s),
      .full_o  (full_s),
      .empty_o (empty_s),
      .count_o (fifo_count_unused_s)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         cur_q   <= '0;
         line_q  <= 128'h0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         line_q  <= line_d;
         resp_q  <= resp_d;
      end
   end

   // RESP waits in place while a retry owns the output register.
   always_comb begin
      case (state_q)
         IDLE:    state_d = empty_s ? IDLE : WAIT;
         WAIT:    state_d = (cnt_q == 3'd0) ? RESP : WAIT;
         RESP:    state_d = rty_s ? RESP : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      err_entry_s = !fta_mreq_is_valid(cur_q.cmd, cur_q.sel);
      idx_s       = cur_q.adr[AWID+3:4];
      pop_s       = (state_q == IDLE) && !empty_s;
      access_s    = (state_q == WAIT) && (cnt_q == 3'd0);
      wr_s        = access_s && cur_q.we && !err_entry_s;
      cur_d       = pop_s ? head_s : cur_q;
      if (pop_s) begin
         cnt_d = 3'(LAT);
      end else if ((state_q == WAIT) && (cnt_q != 3'd0)) begin
         cnt_d = cnt_q - 3'd1;
      end else begin
         cnt_d = cnt_q;
      end
      if (access_s) begin
         line_d = (!cur_q.we && !err_entry_s) ? rd_line_s : 128'h0;
      end else begin
         line_d = line_q;
      end
      resp_d = '0;
      if (rty_s) begin
         resp_d.tid = ftas_req.tid;
         resp_d.rty = 1'b1;
         resp_d.adr = ftas_req.adr;
      end else if (state_q == RESP) begin
         resp_d.tid = cur_q.tid;
         resp_d.adr = cur_q.adr;
         resp_d.dat = line_q;
`ifdef FTA_MEM_RESPONDER_ERR_EN
         resp_d.ack = !err_entry_s;
         resp_d.err = err_entry_s;
`else
         resp_d.ack = 1'b1;
`endif
      end else begin
         resp_d = '0;
      end
   end

   always_comb begin
      rd_line_s = 128'h0;
      for (int i = 0; i < 16; i++) begin
         rd_line_s[8*i +: 8] = ram_q[i][idx_s];
      end
   end

   // Line RAM has no reset so contents survive rst_ni.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 16; i++) begin
         if (wr_s && cur_q.sel[i]) begin
            ram_q[i][idx_s] <= cur_q.data1[8*i +: 8];
         end
      end
   end

   assign ftas_resp = resp_q;

endmodule

// File: tb/tb_fta_mem_responder.sv
// Self-checking bench for fta_mem_responder: directed scenarios plus random
// traffic, every cycle compared against a timestamp-based transaction model.
module tb_fta_mem_responder;
   import fta_bus_pkg::*;

   localparam logic [31:0] BASE = 32'hFFF00000;
   localparam logic [31:0] MASK = 32'hFFFF0000;
   localparam int          LAT  = 7;
   localparam int          QDEP = 4;

   logic                 clk_i  = 1'b0;
   logic                 rst_ni = 1'b0;
   fta_cmd_request128_t  ftas_req = '0;
   fta_cmd_response128_t ftas_resp;

   fta_mem_responder #(.BASE(BASE), .MASK(MASK), .AWID(12), .QDEP(QDEP), .LAT(LAT)) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .ftas_req  (ftas_req),
      .ftas_resp (ftas_resp)
   );

   always #5 clk_i = ~clk_i;

   int ncmp = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // Reference model: a request queue plus one engine slot with timestamps.
   fta_cmd_request128_t  mq[$];
   logic [127:0]         mram [int];
   bit                   eng_busy = 1'b0;
   fta_cmd_request128_t  eng_r;
   logic [127:0]         eng_dat;
   int                   acc_at, drv_at, free_at = 0, ecnt = 0;
   fta_cmd_response128_t exp_resp;

   fta_cmd_response128_t last_ack, last_err;
   int                   last_ack_at, last_err_at, n_resp;
   int                   ack_tids[$], rty_tids[$], rty_at[$];
   logic [127:0]         init_line [8];

   function automatic bit req_ok(input fta_cmd_request128_t r);
      return (r.sel != 16'h0000) && ((r.cmd == CMD_LOAD) || (r.cmd == CMD_STORE));
   endfunction

   task automatic model_edge();
      fta_cmd_request128_t r;
      bit cs, take, full;
      int idx;
      logic [127:0] line;
      r = ftas_req;
      ecnt++;
      exp_resp = '0;
      if (!rst_ni) begin
         mq.delete();
         eng_busy = 1'b0;
         free_at  = ecnt;
      end else begin
         cs = r.cyc && r.stb && ((r.adr & MASK) == (BASE & MASK));
`ifdef FTA_MEM_RESPONDER_ERR_EN
         take = cs;
`else
         take = cs && req_ok(r);
`endif
         full = (mq.size() == QDEP);
         if (eng_busy && ecnt == acc_at && req_ok(eng_r)) begin
            idx  = int'(eng_r.adr[15:4]);
            line = mram.exists(idx) ? mram[idx] : 128'h0;
            if (eng_r.we) begin
               for (int i = 0; i < 16; i++)
                  if (eng_r.sel[i]) line[8*i +: 8] = eng_r.data1[8*i +: 8];
               mram[idx] = line;
            end else begin
               eng_dat = line;
            end
         end
         if (eng_busy && ecnt >= drv_at && !(take && full)) begin
            exp_resp.tid = eng_r.tid;
            exp_resp.adr = eng_r.adr;
            exp_resp.dat = eng_dat;
            if (req_ok(eng_r)) exp_resp.ack = 1'b1;
            else               exp_resp.err = 1'b1;
            eng_busy = 1'b0;
            free_at  = ecnt + 1;
         end else if (!eng_busy && ecnt >= free_at && mq.size() != 0) begin
            eng_r    = mq.pop_front();
            eng_busy = 1'b1;
            eng_dat  = 128'h0;
            acc_at   = ecnt + LAT + 1;
            drv_at   = ecnt + LAT + 2;
         end
         if (take && full) begin
            exp_resp.tid = r.tid;
            exp_resp.rty = 1'b1;
            exp_resp.adr = r.adr;
         end else if (take) begin
            mq.push_back(r);
         end
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      model_edge();
      #1;
      chk("resp", 256'(ftas_resp), 256'(exp_resp));
      if (ftas_resp.ack || ftas_resp.rty || ftas_resp.err) n_resp++;
      if (ftas_resp.ack) begin
         last_ack    = ftas_resp;
         last_ack_at = ecnt;
         ack_tids.push_back(int'(ftas_resp.tid));
      end
      if (ftas_resp.err) begin
         last_err    = ftas_resp;
         last_err_at = ecnt;
      end
      if (ftas_resp.rty) begin
         rty_tids.push_back(int'(ftas_resp.tid));
         rty_at.push_back(ecnt);
      end
   endtask

   task automatic idle(input int n);
      ftas_req = '0;
      repeat (n) step();
   endtask

   task automatic send(input fta_cmd_t cmd, input logic [7:0] tid, input logic [31:0] adr,
                       input logic [15:0] sel, input logic [127:0] d);
      ftas_req.cmd   = cmd;
      ftas_req.tid   = tid;
      ftas_req.cyc   = 1'b1;
      ftas_req.stb   = 1'b1;
      ftas_req.we    = (cmd == CMD_STORE);
      ftas_req.sel   = sel;
      ftas_req.adr   = adr;
      ftas_req.data1 = d;
      step();
      ftas_req = '0;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   int req_at;
   int send_at [7];

   initial begin
      // Reset state
      repeat (2) step();
      chk("reset_resp", 256'(ftas_resp), 256'(0));
      rst_ni = 1'b1;
      idle(2);

      // Fill lines 0..7 with known contents
      for (int i = 0; i < 8; i++) begin
         init_line[i] = (i == 5) ? {16{8'hAA}} : rnd128();
         send(CMD_STORE, 8'(8'h80 + i), BASE | 32'(i << 4), 16'hFFFF, init_line[i]);
         idle(LAT + 4);
      end

      // Write then read, with uncontended latency
      last_ack_at = -1;
      send(CMD_STORE, 8'd3, 32'hFFF00040, 16'h00FF, {64'hDEADBEEFCAFEF00D, 64'h0011223344556677});
      req_at = ecnt;
      idle(LAT + 5);
      chk("wr_tid", 256'(last_ack.tid), 256'(8'd3));
      chk("wr_dat", 256'(last_ack.dat), 256'(0));
      chk("wr_latency", 256'(last_ack_at - req_at), 256'(LAT + 3));
      send(CMD_LOAD, 8'd4, 32'hFFF00040, 16'hFFFF, 128'h0);
      req_at = ecnt;
      idle(LAT + 5);
      chk("rd_tid", 256'(last_ack.tid), 256'(8'd4));
      chk("rd_lo", 256'(last_ack.dat[63:0]), 256'(64'h0011223344556677));
      chk("rd_hi", 256'(last_ack.dat[127:64]), 256'(init_line[4][127:64]));
      chk("rd_latency", 256'(last_ack_at - req_at), 256'(LAT + 3));

      // Byte lanes 0 and 15 only
      send(CMD_STORE, 8'd10, 32'hFFF00050, 16'h8001, {16{8'h5C}});
      idle(LAT + 4);
      send(CMD_LOAD, 8'd11, 32'hFFF00050, 16'hFFFF, 128'h0);
      idle(LAT + 5);
      chk("lanes", 256'(last_ack.dat), 256'({8'h5C, {14{8'hAA}}, 8'h5C}));

      // Queue full: tid 0 occupies the engine, 1..4 fill the queue, 5 and 6 retry
      ack_tids.delete();
      rty_tids.delete();
      rty_at.delete();
      for (int t = 0; t < 7; t++) begin
         send(CMD_LOAD, 8'(t), BASE | 32'(t << 4), 16'hFFFF, 128'h0);
         send_at[t] = ecnt;
      end
      idle(60);
      chk("rty_count", 256'(rty_tids.size()), 256'(2));
      if (rty_tids.size() == 2) begin
         chk("rty_tid0", 256'(rty_tids[0]), 256'(5));
         chk("rty_tid1", 256'(rty_tids[1]), 256'(6));
         chk("rty_at0", 256'(rty_at[0]), 256'(send_at[5]));
         chk("rty_at1", 256'(rty_at[1]), 256'(send_at[6]));
      end
      chk("ack_count", 256'(ack_tids.size()), 256'(5));
      for (int k = 0; k < ack_tids.size() && k < 5; k++)
         chk("ack_order", 256'(ack_tids[k]), 256'(k));

      // Out of window: silent and leaves the queue empty
      n_resp = 0;
      send(CMD_LOAD, 8'd7, 32'h00001000, 16'hFFFF, 128'h0);
      idle(20);
      chk("oow_silent", 256'(n_resp), 256'(0));
      send(CMD_LOAD, 8'd8, 32'hFFF00010, 16'hFFFF, 128'h0);
      req_at = ecnt;
      idle(LAT + 5);
      chk("oow_next_latency", 256'(last_ack_at - req_at), 256'(LAT + 3));
      chk("oow_next_dat", 256'(last_ack.dat), 256'(init_line[1]));

      // sel == 0 request
      n_resp = 0;
      last_err_at = -1;
      send(CMD_LOAD, 8'd9, 32'hFFF00020, 16'h0000, 128'h0);
      req_at = ecnt;
      idle(LAT + 5);
`ifdef FTA_MEM_RESPONDER_ERR_EN
      chk("err_tid", 256'(last_err.tid), 256'(8'd9));
      chk("err_ack", 256'(last_err.ack), 256'(0));
      chk("err_latency", 256'(last_err_at - req_at), 256'(LAT + 3));
`else
      chk("sel0_silent", 256'(n_resp), 256'(0));
`endif

      // Reset while in WAIT with three entries queued; in-flight stores are lost
      for (int t = 0; t < 4; t++)
         send(CMD_STORE, 8'(20 + t), BASE | 32'(t << 4), 16'hFFFF, {4{32'hBAD0BAD0}});
      idle(3);
      rst_ni = 1'b0;
      #1;
      chk("rst_in_wait", 256'(ftas_resp), 256'(0));
      idle(2);
      rst_ni = 1'b1;
      n_resp = 0;
      idle(20);
      chk("no_stale", 256'(n_resp), 256'(0));
      for (int t = 0; t < 4; t++) begin
         send(CMD_LOAD, 8'(40 + t), BASE | 32'(t << 4), 16'hFFFF, 128'h0);
         idle(LAT + 4);
         chk("post_rst_data", 256'(last_ack.dat), 256'(init_line[t]));
      end

      // Reset while ack is being driven
      send(CMD_LOAD, 8'd30, BASE, 16'hFFFF, 128'h0);
      idle(LAT + 3);
      chk("ack_pre_rst", 256'(ftas_resp.ack), 256'(1));
      rst_ni = 1'b0;
      #1;
      chk("rst_async_ack", 256'(ftas_resp), 256'(0));
      idle(2);
      rst_ni = 1'b1;
      idle(2);

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 1) == 0) begin
            idle(1);
         end else begin
            fta_cmd_t cmd;
            cmd = ($urandom_range(0, 9) < 8) ? (($urandom_range(0, 1) == 0) ? CMD_LOAD : CMD_STORE)
                                              : fta_cmd_t'($urandom_range(0, 4));
            ftas_req.cmd   = cmd;
            ftas_req.tid   = 8'($urandom);
            ftas_req.cyc   = ($urandom_range(0, 19) != 0);
            ftas_req.stb   = ($urandom_range(0, 19) != 0);
            ftas_req.we    = (cmd == CMD_STORE);
            ftas_req.sel   = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
            ftas_req.adr   = ($urandom_range(0, 9) == 0) ? ($urandom & 32'h7FFFFFFF)
                           : (BASE | 32'($urandom_range(0, 7) << 4) | 32'($urandom_range(0, 15)));
            ftas_req.data1 = rnd128();
            step();
         end
      end
      idle(60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
